// File: rtl/joojump_button_pio.sv
// Debounced, edge-capturing button input port for the JooJump Avalon-MM fabric.
// Four word registers: debounced DATA, synchronised RAW, IRQMASK and W1C EDGECAP.
module joojump_button_pio #(
    parameter int WIDTH           = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    // Count value on which the next mismatching cycle completes the debounce.
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_d [SYNC_STAGES];
    logic [CW-1:0]    cnt_q  [WIDTH];
    logic [CW-1:0]    cnt_d  [WIDTH];
    logic [WIDTH-1:0] raw;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] irqmask_q, irqmask_d;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic [WIDTH-1:0] rise, fall, capture, clr;
    logic [31:0]      readdata_q, readdata_d;
    logic             wr_en;

    always_comb begin
        sync_d[0] = in_port;
        for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
    end

    assign raw = sync_q[SYNC_STAGES-1];

    always_comb begin
        data_d = data_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (raw[i] != data_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    data_d[i] = raw[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    assign rise  = data_d & ~data_q;
    assign fall  = ~data_d & data_q;
    assign wr_en = chipselect & ~write_n;

    always_comb begin
        if (EDGE_TYPE == 0) begin
            capture = rise;
        end else if (EDGE_TYPE == 1) begin
            capture = fall;
        end else begin
            capture = rise | fall;
        end
    end

    // A capture on the same edge as a software clear must survive, so set is ORed last.
    always_comb begin
        clr       = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
        edgecap_d = (edgecap_q & ~clr) | capture;
        irqmask_d = (wr_en && address == 2'd2) ? writedata[WIDTH-1:0] : irqmask_q;
    end

    always_comb begin
        readdata_d = '0;
        case (address)
            2'd0:    readdata_d = 32'(data_q);
            2'd1:    readdata_d = 32'(raw);
            2'd2:    readdata_d = 32'(irqmask_q);
            default: readdata_d = 32'(edgecap_q);
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
            data_q     <= '0;
            irqmask_q  <= '0;
            edgecap_q  <= '0;
            readdata_q <= '0;
        end else begin
            sync_q     <= sync_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            irqmask_q  <= irqmask_d;
            edgecap_q  <= edgecap_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(edgecap_q & irqmask_q);

    generate
        if (WIDTH < 32) begin : g_wd_upper
            logic unused_wd_upper;
            assign unused_wd_upper = ^writedata[31:WIDTH];
        end
    endgenerate

endmodule
